fft_iter_ctrl: RTL and testbench

Sequencing controller for the in-place iterative radix-2 DIT FFT core. It runs AWL stages of N/2 butterflies over a dual-port sample RAM, with N = 2^AWL and input already in bit-reversed order. Each cycle it issues one butterfly's read addresses and twiddle address, and returns the matching write-back addresses BUT_LAT cycles later. It inserts a drain gap between stages so a stage never reads a location still in flight. It owns the RAM-block flag that locks external RAM access while a transform runs.

---
 rtl/fft_iter_ctrl_pkg.sv | 17 +
 rtl/fft_iter_ctrl_addr_gen.sv | 32 +++
 rtl/fft_iter_ctrl.sv | 131 +++++++++++++
 tb/tb_fft_iter_ctrl.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fft_iter_ctrl_pkg.sv
// Shared types and constants for the iterative radix-2 DIT FFT sequencing controller.
package fft_iter_ctrl_pkg;

   localparam int STAGE_W = 4;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2,
      ST_DONE  = 2'd3
   } state_e;

   function automatic int fft_points(input int awl);
      return 1 << awl;
   endfunction

endpackage

// File: rtl/fft_iter_ctrl_addr_gen.sv
// Butterfly address generator: maps {stage, k} to operand addresses and twiddle index.
// Purely combinational so the twiddle-ROM and bit-reverse checkers can reuse it.
module fft_addr_gen
   import fft_iter_ctrl_pkg::*;
#(
   parameter int AWL = 8
) (
   input  logic [STAGE_W-1:0] stage_i,
   input  logic [AWL-2:0]     k_i,
   output logic [AWL-1:0]     a_addr_o,
   output logic [AWL-1:0]     b_addr_o,
   output logic [AWL-2:0]     w_addr_o
);

   logic [AWL-1:0]     k_ext;
   logic [AWL-1:0]     half;
   logic [AWL-1:0]     low_mask;
   logic [STAGE_W-1:0] w_shift;

   // NOTE: every signal gets a value on every path through always_comb, otherwise a latch is inferred.
   always_comb begin
      k_ext    = {1'b0, k_i};
      half     = AWL'(1) << stage_i;
      low_mask = half - AWL'(1);
      w_shift  = STAGE_W'(AWL - 1) - stage_i;
      // Open a zero at bit s: keep the low s bits, move the rest up one position.
      a_addr_o = ((k_ext & ~low_mask) << 1) | (k_ext & low_mask);
      b_addr_o = a_addr_o | half;
      w_addr_o = (k_i & low_mask[AWL-2:0]) << w_shift;
   end

endmodule

// File: rtl/fft_iter_ctrl.sv
// Stage/butterfly sequencer for the in-place radix-2 FFT: issues reads, delays them into
// write-backs, and drains the datapath between stages so no stage reads an in-flight location.
module fft_iter_ctrl
   import fft_iter_ctrl_pkg::*;
#(
   parameter int AWL     = 8,
   parameter int BUT_LAT = 4
) (
   input  logic               CLK,
   input  logic               RST,
   input  logic               EN,
   input  logic               START,
   output logic               o_RD_EN,
   output logic [AWL-1:0]     o_A_ADDR,
   output logic [AWL-1:0]     o_B_ADDR,
   output logic [AWL-2:0]     o_W_ADDR,
   output logic               o_WR_EN,
   output logic [AWL-1:0]     o_WA_ADDR,
   output logic [AWL-1:0]     o_WB_ADDR,
   output logic [STAGE_W-1:0] o_STAGE,
   output logic               o_RAM_BLOCK,
   output logic               o_DONE
);

   localparam int KW     = AWL - 1;
   localparam int HALF_N = fft_points(AWL) / 2;
   localparam int DCW    = $clog2(BUT_LAT + 1);

   localparam logic [KW-1:0]      K_LAST = KW'(HALF_N - 1);
   localparam logic [STAGE_W-1:0] S_LAST = STAGE_W'(AWL - 1);
   localparam logic [DCW-1:0]     D_LAST = DCW'(BUT_LAT - 1);

   typedef struct packed {
      logic           valid;
      logic [AWL-1:0] a;
      logic [AWL-1:0] b;
   } wb_t;

   state_e             state_q;
   logic [STAGE_W-1:0] stage_q;
   logic [KW-1:0]      k_q;
   logic [DCW-1:0]     drain_q;

   logic               rd_en;
   logic [AWL-1:0]     gen_a, gen_b;
   logic [AWL-2:0]     gen_w;
   wb_t                pipe_in;
   wb_t                pipe_q [BUT_LAT];

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state_q <= ST_IDLE;
         stage_q <= '0;
         k_q     <= '0;
         drain_q <= '0;
      end else if (EN) begin
         case (state_q)
            ST_IDLE: begin
               if (START) begin
                  state_q <= ST_RUN;
                  stage_q <= '0;
                  k_q     <= '0;
               end
            end
            ST_RUN: begin
               if (k_q == K_LAST) begin
                  state_q <= ST_DRAIN;
                  drain_q <= '0;
               end else begin
                  k_q <= k_q + KW'(1);
               end
            end
            ST_DRAIN: begin
               if (drain_q != D_LAST) begin
                  drain_q <= drain_q + DCW'(1);
               end else if (stage_q == S_LAST) begin
                  state_q <= ST_DONE;
               end else begin
                  state_q <= ST_RUN;
                  stage_q <= stage_q + STAGE_W'(1);
                  k_q     <= '0;
               end
            end
            default: begin
               state_q <= ST_IDLE;
               stage_q <= '0;
            end
         endcase
      end
   end

   fft_addr_gen #(.AWL(AWL)) u_addr_gen (
      .stage_i  (stage_q),
      .k_i      (k_q),
      .a_addr_o (gen_a),
      .b_addr_o (gen_b),
      .w_addr_o (gen_w)
   );

   assign rd_en   = (state_q == ST_RUN);
   assign pipe_in = '{valid: rd_en, a: o_A_ADDR, b: o_B_ADDR};

   // NOTE: the delay line is reset, not left as plain storage, because its valid bits are live
   // write strobes and an abort must discard anything still in flight.
   for (genvar i = 0; i < BUT_LAT; i++) begin : g_dly
      if (i == 0) begin : g_head
         always_ff @(posedge CLK or negedge RST) begin
            if (!RST)    pipe_q[i] <= '0;
            else if (EN) pipe_q[i] <= pipe_in;
         end
      end else begin : g_tail
         always_ff @(posedge CLK or negedge RST) begin
            if (!RST)    pipe_q[i] <= '0;
            else if (EN) pipe_q[i] <= pipe_q[i-1];
         end
      end
   end

   assign o_RD_EN     = rd_en;
   assign o_A_ADDR    = rd_en ? gen_a : '0;
   assign o_B_ADDR    = rd_en ? gen_b : '0;
   assign o_W_ADDR    = rd_en ? gen_w : '0;
   assign o_WR_EN     = pipe_q[BUT_LAT-1].valid;
   assign o_WA_ADDR   = pipe_q[BUT_LAT-1].a;
   assign o_WB_ADDR   = pipe_q[BUT_LAT-1].b;
   assign o_STAGE     = stage_q;
   assign o_RAM_BLOCK = (state_q != ST_IDLE);
   assign o_DONE      = (state_q == ST_DONE);

endmodule

// File: tb/tb_fft_iter_ctrl.sv
// Directed bench: small instance (AWL=3, BUT_LAT=2) for exact traces, default instance
// (AWL=8, BUT_LAT=4) for back-to-back transforms with START held high.
module tb_fft_iter_ctrl;

   // {rd, a[3], b[3], w[2], wr, wa[3], wb[3], stage[4], ram_block, done}
   typedef logic [21:0] vec_t;

   logic clk, rst_n;
   logic en_s, start_s, en_d, start_d;

   logic       rd_s, wr_s, rb_s, dn_s;
   logic [2:0] a_s, b_s, wa_s, wb_s;
   logic [1:0] w_s;
   logic [3:0] stg_s;

   logic       rd_d, wr_d, rb_d, dn_d;
   logic [7:0] a_d, b_d, wa_d, wb_d;
   logic [6:0] w_d;
   logic [3:0] stg_d;

   int n_tests = 0;
   int n_fail  = 0;

   logic [2:0] exp_a [12] = '{3'd0, 3'd2, 3'd4, 3'd6, 3'd0, 3'd1, 3'd4, 3'd5, 3'd0, 3'd1, 3'd2, 3'd3};
   logic [2:0] exp_b [12] = '{3'd1, 3'd3, 3'd5, 3'd7, 3'd2, 3'd3, 3'd6, 3'd7, 3'd4, 3'd5, 3'd6, 3'd7};
   logic [1:0] exp_w [12] = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd2, 2'd0, 2'd2, 2'd0, 2'd1, 2'd2, 2'd3};

   vec_t obs_q [22];
   int   held_c [$];
   vec_t held_v [$];
   int   busy_s;

   fft_iter_ctrl #(.AWL(3), .BUT_LAT(2)) dut_s (
      .CLK(clk), .RST(rst_n), .EN(en_s), .START(start_s),
      .o_RD_EN(rd_s), .o_A_ADDR(a_s), .o_B_ADDR(b_s), .o_W_ADDR(w_s),
      .o_WR_EN(wr_s), .o_WA_ADDR(wa_s), .o_WB_ADDR(wb_s),
      .o_STAGE(stg_s), .o_RAM_BLOCK(rb_s), .o_DONE(dn_s)
   );

   fft_iter_ctrl dut_d (
      .CLK(clk), .RST(rst_n), .EN(en_d), .START(start_d),
      .o_RD_EN(rd_d), .o_A_ADDR(a_d), .o_B_ADDR(b_d), .o_W_ADDR(w_d),
      .o_WR_EN(wr_d), .o_WA_ADDR(wa_d), .o_WB_ADDR(wb_d),
      .o_STAGE(stg_d), .o_RAM_BLOCK(rb_d), .o_DONE(dn_d)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic vec_t cur_s();
      return {rd_s, a_s, b_s, w_s, wr_s, wa_s, wb_s, stg_s, rb_s, dn_s};
   endfunction

   function automatic logic [46:0] cur_d();
      return {rd_d, a_d, b_d, w_d, wr_d, wa_d, wb_d, stg_d, rb_d, dn_d};
   endfunction

   // Small-instance schedule: each stage is 4 RUN cycles + 2 DRAIN cycles, DONE at cycle 18.
   function automatic int rd_idx(input int c);
      if (c < 0 || c > 17) return -1;
      if ((c % 6) < 4) return (c / 6) * 4 + (c % 6);
      return -1;
   endfunction

   function automatic vec_t exp_vec(input int c);
      int r, q;
      logic [3:0] stg;
      vec_t v;
      r   = rd_idx(c);
      q   = rd_idx(c - 2);
      stg = (c < 6 || c > 18) ? 4'd0 : (c < 12) ? 4'd1 : 4'd2;
      v   = '0;
      if (r >= 0) v[21:13] = {1'b1, exp_a[r], exp_b[r], exp_w[r]};
      if (q >= 0) v[12:6]  = {1'b1, exp_a[q], exp_b[q]};
      v[5:2] = stg;
      v[1]   = (c >= 0 && c <= 18);
      v[0]   = (c == 18);
      return v;
   endfunction

   // Starts one small transform, records one sample per EN-qualified cycle; EN is dropped
   // for 5 cycles after the samples at logical cycles g1 and g2.
   task automatic run_trace(input int g1, input int g2, input int stop_at);
      held_c.delete();
      held_v.delete();
      busy_s = 0;
      @(negedge clk) start_s = 1'b1;
      @(negedge clk) start_s = 1'b0;
      for (int c = 0; c <= stop_at; c++) begin
         if (c > 0) @(negedge clk);
         obs_q[c] = cur_s();
         busy_s  += int'(rb_s);
         if (c == g1 || c == g2) begin
            en_s = 1'b0;
            repeat (5) begin
               @(negedge clk);
               held_c.push_back(c);
               held_v.push_back(cur_s());
               busy_s += int'(rb_s);
            end
            en_s = 1'b1;
         end
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0; en_s = 1'b1; en_d = 1'b1; start_s = 1'b0; start_d = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         n_tests++;
         if (cur_s() !== '0 || cur_d() !== '0) begin
            n_fail++;
            $display("FAIL reset_idle cyc=%0d small=%h big=%h expected all zero", i, cur_s(), cur_d());
         end
      end
   endtask

   task automatic test_addr_seq();
      int hazards, ngaps, badgap, last_rd;
      vec_t o, p;
      run_trace(-1, -1, 21);
      for (int c = 0; c < 22; c++) begin
         n_tests++;
         if (obs_q[c] !== exp_vec(c)) begin
            n_fail++;
            $display("FAIL addr_seq c=%0d got %h expected %h", c, obs_q[c], exp_vec(c));
         end
      end
      hazards = 0; ngaps = 0; badgap = 0; last_rd = -1;
      for (int c = 0; c < 22; c++) begin
         o = obs_q[c];
         if (o[21]) begin
            for (int d = c - 2; d < c; d++) begin
               if (d >= 0) begin
                  p = obs_q[d];
                  if (p[21] && (o[20:18] == p[20:18] || o[20:18] == p[17:15] ||
                                o[17:15] == p[20:18] || o[17:15] == p[17:15]))
                     hazards++;
               end
            end
            if (last_rd >= 0 && c - last_rd > 1) begin
               ngaps++;
               if (c - last_rd != 3) badgap++;
            end
            last_rd = c;
         end
      end
      n_tests++;
      if (hazards !== 0) begin
         n_fail++;
         $display("FAIL stage_hazard got %0d overlaps expected 0", hazards);
      end
      n_tests++;
      if (ngaps !== 2 || badgap !== 0) begin
         n_fail++;
         $display("FAIL stage_gap got %0d gaps (%0d wrong) expected 2 gaps of 3", ngaps, badgap);
      end
      n_tests++;
      if (busy_s !== 19) begin
         n_fail++;
         $display("FAIL busy_ungated got %0d expected 19", busy_s);
      end
   endtask

   task automatic test_en_gating();
      run_trace(2, 10, 21);
      for (int c = 0; c < 22; c++) begin
         n_tests++;
         if (obs_q[c] !== exp_vec(c)) begin
            n_fail++;
            $display("FAIL en_gate c=%0d got %h expected %h", c, obs_q[c], exp_vec(c));
         end
      end
      n_tests++;
      if (held_c.size() !== 10) begin
         n_fail++;
         $display("FAIL en_hold_count got %0d expected 10", held_c.size());
      end
      foreach (held_v[i]) begin
         n_tests++;
         if (held_v[i] !== exp_vec(held_c[i])) begin
            n_fail++;
            $display("FAIL en_hold c=%0d got %h expected %h", held_c[i], held_v[i], exp_vec(held_c[i]));
         end
      end
      n_tests++;
      if (busy_s !== 29) begin
         n_fail++;
         $display("FAIL busy_gated got %0d expected 29", busy_s);
      end
   endtask

   task automatic test_abort();
      run_trace(-1, -1, 8);
      n_tests++;
      if (obs_q[8] !== exp_vec(8)) begin
         n_fail++;
         $display("FAIL abort_pre got %h expected %h", obs_q[8], exp_vec(8));
      end
      #2 rst_n = 1'b0;
      #1;
      n_tests++;
      if (cur_s() !== '0 || cur_d() !== '0) begin
         n_fail++;
         $display("FAIL abort_async small=%h big=%h expected all zero", cur_s(), cur_d());
      end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         n_tests++;
         if (cur_s() !== '0) begin
            n_fail++;
            $display("FAIL abort_idle cyc=%0d got %h expected 0", i, cur_s());
         end
      end
      run_trace(-1, -1, 21);
      for (int c = 0; c < 22; c++) begin
         n_tests++;
         if (obs_q[c] !== exp_vec(c)) begin
            n_fail++;
            $display("FAIL abort_replay c=%0d got %h expected %h", c, obs_q[c], exp_vec(c));
         end
      end
   endtask

   task automatic test_back_to_back();
      int idle, busy, wr, dn;
      logic dn_last;
      @(negedge clk) start_d = 1'b1;
      for (int t = 0; t < 2; t++) begin
         idle = 0;
         while (!rb_d && idle < 10) begin
            idle++;
            @(negedge clk);
         end
         n_tests++;
         if (rb_d !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_start t=%0d timed out, ram_block=%b expected 1", t, rb_d);
         end
         if (t > 0) begin
            n_tests++;
            if (idle !== 1) begin
               n_fail++;
               $display("FAIL b2b_idle_gap got %0d expected 1", idle);
            end
            start_d = 1'b0;
         end
         busy = 0; wr = 0; dn = 0; dn_last = 1'b0;
         while (rb_d && busy < 2000) begin
            busy++;
            wr     += int'(wr_d);
            dn     += int'(dn_d);
            dn_last = dn_d;
            @(negedge clk);
         end
         n_tests++;
         if (busy !== 1057) begin
            n_fail++;
            $display("FAIL b2b_busy t=%0d got %0d expected 1057", t, busy);
         end
         n_tests++;
         if (wr !== 1024) begin
            n_fail++;
            $display("FAIL b2b_writes t=%0d got %0d expected 1024", t, wr);
         end
         n_tests++;
         if (dn !== 1 || dn_last !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_done t=%0d got %0d pulses (last=%b) expected 1 in last cycle", t, dn, dn_last);
         end
      end
      repeat (5) @(negedge clk);
      n_tests++;
      if (cur_d() !== '0) begin
         n_fail++;
         $display("FAIL b2b_final_idle got %h expected 0", cur_d());
      end
   endtask

   initial begin
      test_reset();
      test_addr_seq();
      test_en_gating();
      test_abort();
      test_back_to_back();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog expired at %0t expected completion earlier", $time);
      $fatal(1, "watchdog");
   end

endmodule
